// File: rtl/fnorm_sched_pkg.sv
// Shared types and constants for the normalizer scheduler.
// Default widths match the standard 3-port, 9-bit-tag configuration.
package fpu_sched_pkg;

  localparam int NORM_W    = 82;
  localparam int NORM_LAT  = 2;
  localparam int NORM_NREQ = 3;
  localparam int NORM_TAGW = 9;

  typedef struct packed {
    logic                 vld;
    logic [NORM_NREQ-1:0] src;
    logic [NORM_TAGW-1:0] tag;
  } nslot_t;

endpackage

// File: rtl/fnorm_sched_if.sv
// Requester/consumer side of the shared normalizer scheduler.
// The slave modport is the scheduler; the master is the issue/consume side.
interface fnorm_sched_if import fpu_sched_pkg::*; #(
  parameter int NREQ = NORM_NREQ,
  parameter int LAT  = NORM_LAT,
  parameter int TAGW = NORM_TAGW
);
  localparam int OCCW = $clog2(LAT + 1) + 1;

  logic [NREQ-1:0]             req_vld;
  logic [NREQ-1:0][NORM_W-1:0] req_A;
  logic [NREQ-1:0]             req_isDBL;
  logic [NREQ-1:0]             req_isEXT;
  logic [NREQ-1:0][TAGW-1:0]   req_tag;
  logic [NREQ-1:0]             req_gnt;
  logic [NREQ-1:0]             kill;
  logic                        res_vld;
  logic [NREQ-1:0]             res_src;
  logic [TAGW-1:0]             res_tag;
  logic [NORM_W-1:0]           res_data;
  logic                        res_rdy;
  logic [OCCW-1:0]             occ;

  modport slave (
    input  req_vld, req_A, req_isDBL, req_isEXT, req_tag, kill, res_rdy,
    output req_gnt, res_vld, res_src, res_tag, res_data, occ
  );

  modport master (
    output req_vld, req_A, req_isDBL, req_isEXT, req_tag, kill, res_rdy,
    input  req_gnt, res_vld, res_src, res_tag, res_data, occ
  );

endinterface

// File: rtl/fnorm_rr_pick.sv
// Round-robin picker: rotate the eligible mask so rr_ptr is bit 0,
// isolate the lowest set bit, then rotate the one-hot grant back.
module fnorm_rr_pick #(
  parameter int NREQ = 3,
  parameter int PTRW = 2
) (
  input  logic [NREQ-1:0] i_elig,
  input  logic [PTRW-1:0] i_ptr,
  output logic [NREQ-1:0] o_gnt
);

  logic [NREQ-1:0] w_rot;
  logic [NREQ-1:0] w_rot_gnt;

  // NOTE: every output of a combinational block gets a default first, so
  // no path through the block leaves a value held and infers a latch.
  always_comb begin
    w_rot     = '0;
    w_rot_gnt = '0;
    o_gnt     = '0;
    for (int j = 0; j < NREQ; j++) begin
      for (int m = 0; m < NREQ; m++) begin
        if (m == (j + int'(i_ptr)) % NREQ) w_rot[j] = i_elig[m];
      end
    end
    w_rot_gnt = w_rot & (~w_rot + NREQ'(1));
    for (int j = 0; j < NREQ; j++) begin
      for (int m = 0; m < NREQ; m++) begin
        if (m == (j + int'(i_ptr)) % NREQ) o_gnt[m] = w_rot_gnt[j];
      end
    end
  end

endmodule

// File: rtl/fnorm_sched.sv
// Shares one fixed-latency normalizeD pipe between NREQ issue ports,
// tracking owner and tag of each in-flight op alongside the pipe.
module fnorm_sched import fpu_sched_pkg::*; #(
  parameter int NREQ = NORM_NREQ,
  parameter int LAT  = NORM_LAT,
  parameter int TAGW = NORM_TAGW
) (
  input  logic              clk,
  input  logic              rst,
  fnorm_sched_if.slave      bus,
  output logic [NORM_W-1:0] nrm_A,
  output logic              nrm_isDBL,
  output logic              nrm_isEXT,
  output logic              nrm_en,
  output logic              nrm_clkEn,
  input  logic [NORM_W-1:0] nrm_res
);

  localparam int OCCW = $clog2(LAT + 1) + 1;
  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic            vld;
    logic [NREQ-1:0] src;
    logic [TAGW-1:0] tag;
  } slot_t;

  slot_t           r_slot [LAT];
  logic [PTRW-1:0] r_rr_ptr;
  logic [OCCW-1:0] r_occ;

  logic [LAT-1:0]  w_kill_hit;
  logic [OCCW-1:0] w_nkill;
  logic            w_res_vld;
  logic            w_stall;
  logic            w_acc;
  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_gnt;
  logic [TAGW-1:0] w_gnt_tag;
  logic [PTRW-1:0] w_rr_nxt;

  // A killed output entry is masked here, which also releases any stall it held.
  always_comb begin
    w_kill_hit = '0;
    w_nkill    = '0;
    for (int k = 0; k < LAT; k++) begin
      w_kill_hit[k] = r_slot[k].vld & (|(r_slot[k].src & bus.kill));
      w_nkill       = w_nkill + OCCW'(w_kill_hit[k]);
    end
    w_res_vld = r_slot[LAT-1].vld & ~w_kill_hit[LAT-1];
    w_stall   = w_res_vld & ~bus.res_rdy;
    w_acc     = w_res_vld & bus.res_rdy;
    w_elig    = bus.req_vld & ~bus.kill & {NREQ{~w_stall & ~rst}};
  end

  fnorm_rr_pick #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_pick (
    .i_elig (w_elig),
    .i_ptr  (r_rr_ptr),
    .o_gnt  (w_gnt)
  );

  always_comb begin
    nrm_A     = '0;
    nrm_isDBL = 1'b0;
    nrm_isEXT = 1'b0;
    w_gnt_tag = '0;
    w_rr_nxt  = r_rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        nrm_A     = bus.req_A[i];
        nrm_isDBL = bus.req_isDBL[i];
        nrm_isEXT = bus.req_isEXT[i];
        w_gnt_tag = bus.req_tag[i];
        w_rr_nxt  = (i == NREQ - 1) ? '0 : PTRW'(i + 1);
      end
    end
  end

  assign nrm_en       = |w_gnt;
  assign nrm_clkEn    = ~w_stall;
  assign bus.req_gnt  = w_gnt;
  assign bus.res_vld  = w_res_vld;
  assign bus.res_src  = r_slot[LAT-1].src;
  assign bus.res_tag  = r_slot[LAT-1].tag;
  assign bus.res_data = nrm_res;
  assign bus.occ      = r_occ;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: only the valid bits are reset; src/tag are don't-care while invalid,
  // so the payload flops need no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) r_slot[k].vld <= 1'b0;
    end else if (!w_stall) begin
      r_slot[0] <= '{vld: nrm_en, src: w_gnt, tag: w_gnt_tag};
      for (int k = 1; k < LAT; k++) begin
        r_slot[k]     <= r_slot[k-1];
        r_slot[k].vld <= r_slot[k-1].vld & ~w_kill_hit[k-1];
      end
    end else begin
      for (int k = 0; k < LAT; k++) begin
        if (w_kill_hit[k]) r_slot[k].vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_occ <= r_occ + OCCW'(nrm_en) - OCCW'(w_acc) - w_nkill;
      if (nrm_en) r_rr_ptr <= w_rr_nxt;
    end
  end

endmodule

// File: tb/tb_fnorm_sched.sv
// Self-checking bench for fnorm_sched: directed scenarios plus a randomized run,
// all checked against an op-list reference model and a behavioural normalizer stub.
module tb_fnorm_sched;
  import fpu_sched_pkg::*;

  localparam int NREQ = 3;
  localparam int LAT  = 2;
  localparam int TAGW = 9;
  localparam int OCCW = $clog2(LAT + 1) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fnorm_sched_if #(.NREQ(NREQ), .LAT(LAT), .TAGW(TAGW)) tif ();

  logic [NORM_W-1:0] nrm_A;
  logic [NORM_W-1:0] nrm_res;
  logic              nrm_isDBL;
  logic              nrm_isEXT;
  logic              nrm_en;
  logic              nrm_clkEn;

  fnorm_sched #(.NREQ(NREQ), .LAT(LAT), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (tif.slave),
    .nrm_A     (nrm_A),
    .nrm_isDBL (nrm_isDBL),
    .nrm_isEXT (nrm_isEXT),
    .nrm_en    (nrm_en),
    .nrm_clkEn (nrm_clkEn),
    .nrm_res   (nrm_res)
  );

  // Stand-in for normalizeD: a recognisable transform, LAT enabled cycles deep.
  function automatic logic [NORM_W-1:0] norm_fn(input logic [NORM_W-1:0] a,
                                                input logic d, input logic e);
    return {a[NORM_W-2:0], a[NORM_W-1]} ^ {d, e, {(NORM_W-2){1'b0}}};
  endfunction

  logic [NORM_W-1:0] stub [LAT];
  always @(posedge clk) begin
    if (nrm_clkEn) begin
      stub[0] <= nrm_en ? norm_fn(nrm_A, nrm_isDBL, nrm_isEXT) : '0;
      for (int k = 1; k < LAT; k++) stub[k] <= stub[k-1];
    end
  end
  assign nrm_res = stub[LAT-1];

  // Reference model: list of in-flight ops, each with the count of enabled
  // edges since its grant; an op is presented once that count reaches LAT.
  typedef struct {
    int              src;
    logic [TAGW-1:0] tag;
    logic [NORM_W-1:0] a;
    logic            d;
    logic            e;
    int              stage;
  } op_t;

  op_t q[$];
  int  rr;
  int  n_cmp = 0;
  int  n_bad = 0;

  logic [NREQ-1:0]   exp_gnt;
  int                exp_pick;
  logic              exp_res_vld;
  logic              exp_stall;
  logic [NREQ-1:0]   exp_src;
  logic [TAGW-1:0]   exp_tag;
  logic [NORM_W-1:0] exp_data;
  logic [NORM_W-1:0] exp_A;
  logic              exp_d;
  logic              exp_e;
  logic [TAGW-1:0]   exp_ptag;
  int                exp_occ;

  function automatic logic [NORM_W-1:0] rand82();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[NORM_W-1:0];
  endfunction

  task automatic drive(input logic [NREQ-1:0] vld, input logic [NREQ-1:0] kl,
                       input logic rdy);
    tif.req_vld = vld;
    tif.kill    = kl;
    tif.res_rdy = rdy;
    for (int i = 0; i < NREQ; i++) begin
      tif.req_A[i]     = rand82();
      tif.req_tag[i]   = TAGW'($urandom);
      tif.req_isDBL[i] = 1'($urandom);
      tif.req_isEXT[i] = 1'($urandom);
    end
  endtask

  task automatic eval();
    int out_idx;
    #1;
    out_idx = -1;
    foreach (q[j]) if (q[j].stage == LAT) out_idx = j;
    exp_res_vld = 1'b0;
    exp_src = '0; exp_tag = '0; exp_data = '0;
    if (out_idx >= 0) begin
      if (!tif.kill[q[out_idx].src]) begin
        exp_res_vld = 1'b1;
        exp_src  = NREQ'(1) << q[out_idx].src;
        exp_tag  = q[out_idx].tag;
        exp_data = norm_fn(q[out_idx].a, q[out_idx].d, q[out_idx].e);
      end
    end
    exp_stall = exp_res_vld && !tif.res_rdy;
    exp_pick  = -1;
    if (!rst && !exp_stall) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (rr + k) % NREQ;
        if (exp_pick < 0 && tif.req_vld[i] && !tif.kill[i]) exp_pick = i;
      end
    end
    exp_gnt = '0; exp_A = '0; exp_d = 1'b0; exp_e = 1'b0; exp_ptag = '0;
    if (exp_pick >= 0) begin
      exp_gnt  = NREQ'(1) << exp_pick;
      exp_A    = tif.req_A[exp_pick];
      exp_d    = tif.req_isDBL[exp_pick];
      exp_e    = tif.req_isEXT[exp_pick];
      exp_ptag = tif.req_tag[exp_pick];
    end
    exp_occ = q.size();
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      q.delete();
      rr = 0;
    end else begin
      for (int j = q.size() - 1; j >= 0; j--) if (tif.kill[q[j].src]) q.delete(j);
      if (!exp_stall) begin
        for (int j = q.size() - 1; j >= 0; j--) if (q[j].stage == LAT) q.delete(j);
        foreach (q[j]) q[j].stage++;
        if (exp_pick >= 0) begin
          q.push_back('{src: exp_pick, tag: exp_ptag, a: exp_A, d: exp_d, e: exp_e, stage: 1});
          rr = (exp_pick + 1) % NREQ;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int c = 0; c < n; c++) begin
      drive('0, '0, 1'b1);
      eval();
      n_cmp++;
      if (tif.res_vld !== exp_res_vld) begin
        n_bad++; $display("FAIL drain_res_vld: got %b want %b", tif.res_vld, exp_res_vld);
      end
      if (exp_res_vld) begin
        n_cmp++;
        if (tif.res_tag !== exp_tag) begin
          n_bad++; $display("FAIL drain_tag: got %h want %h", tif.res_tag, exp_tag);
        end
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(3'b111, '0, 1'b1);
    step();
    eval();
    n_cmp++;
    if (tif.req_gnt !== exp_gnt) begin
      n_bad++; $display("FAIL reset_gnt: got %b want %b", tif.req_gnt, exp_gnt);
    end
    n_cmp++;
    if (nrm_en !== 1'b0) begin
      n_bad++; $display("FAIL reset_nrm_en: got %b want 0", nrm_en);
    end
    n_cmp++;
    if (tif.res_vld !== exp_res_vld) begin
      n_bad++; $display("FAIL reset_res_vld: got %b want %b", tif.res_vld, exp_res_vld);
    end
    n_cmp++;
    if (int'(tif.occ) !== exp_occ) begin
      n_bad++; $display("FAIL reset_occ: got %0d want %0d", tif.occ, exp_occ);
    end
    step();
    rst = 1'b0;
    drive(3'b111, '0, 1'b1);
    eval();
    n_cmp++;
    if (tif.req_gnt !== 3'b001) begin
      n_bad++; $display("FAIL reset_first_gnt: got %b want 001", tif.req_gnt);
    end
    step();
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 8; c++) begin
      drive(3'b111, '0, 1'b1);
      eval();
      n_cmp++;
      if (tif.req_gnt !== exp_gnt) begin
        n_bad++; $display("FAIL rr_gnt: cycle %0d got %b want %b", c, tif.req_gnt, exp_gnt);
      end
      n_cmp++;
      if (nrm_A !== exp_A) begin
        n_bad++; $display("FAIL rr_nrm_A: cycle %0d got %h want %h", c, nrm_A, exp_A);
      end
      n_cmp++;
      if (tif.res_vld !== exp_res_vld || (exp_res_vld && tif.res_src !== exp_src)) begin
        n_bad++; $display("FAIL rr_res: cycle %0d got vld %b src %b want vld %b src %b",
                          c, tif.res_vld, tif.res_src, exp_res_vld, exp_src);
      end
      n_cmp++;
      if (int'(tif.occ) !== exp_occ || int'(tif.occ) > LAT) begin
        n_bad++; $display("FAIL rr_occ: cycle %0d got %0d want %0d", c, tif.occ, exp_occ);
      end
      step();
    end
  endtask

  task automatic test_stall();
    drain(LAT + 1);
    drive(3'b010, '0, 1'b1);
    tif.req_tag[1] = 9'h1A5;
    eval();
    n_cmp++;
    if (tif.req_gnt !== 3'b010) begin
      n_bad++; $display("FAIL stall_issue_gnt: got %b want 010", tif.req_gnt);
    end
    step();
    drive('0, '0, 1'b1);
    eval();
    step();
    for (int c = 0; c < 3; c++) begin
      drive(3'b111, '0, 1'b0);
      eval();
      n_cmp++;
      if (tif.res_vld !== 1'b1 || tif.res_tag !== 9'h1A5) begin
        n_bad++; $display("FAIL stall_hold: cycle %0d got vld %b tag %h want vld 1 tag 1a5",
                          c, tif.res_vld, tif.res_tag);
      end
      n_cmp++;
      if (nrm_clkEn !== 1'b0 || tif.req_gnt !== 3'b000) begin
        n_bad++; $display("FAIL stall_freeze: cycle %0d got clkEn %b gnt %b want clkEn 0 gnt 000",
                          c, nrm_clkEn, tif.req_gnt);
      end
      step();
    end
    drive('0, '0, 1'b1);
    eval();
    n_cmp++;
    if (tif.res_vld !== 1'b1 || tif.res_data !== exp_data || tif.res_src !== 3'b010) begin
      n_bad++; $display("FAIL stall_deliver: got vld %b src %b data %h want vld 1 src 010 data %h",
                        tif.res_vld, tif.res_src, tif.res_data, exp_data);
    end
    step();
    drive('0, '0, 1'b1);
    eval();
    n_cmp++;
    if (tif.res_vld !== 1'b0) begin
      n_bad++; $display("FAIL stall_once: got vld %b want 0", tif.res_vld);
    end
    step();
  endtask

  task automatic test_kill_stall();
    drain(LAT + 1);
    drive(3'b001, '0, 1'b1); eval(); step();
    drive('0, '0, 1'b1);     eval(); step();
    drive('0, '0, 1'b0);
    eval();
    n_cmp++;
    if (nrm_clkEn !== 1'b0) begin
      n_bad++; $display("FAIL killstall_pre: got clkEn %b want 0", nrm_clkEn);
    end
    step();
    drive(3'b010, 3'b001, 1'b0);
    eval();
    n_cmp++;
    if (tif.res_vld !== 1'b0 || nrm_clkEn !== 1'b1 || tif.req_gnt !== exp_gnt) begin
      n_bad++; $display("FAIL killstall_release: got vld %b clkEn %b gnt %b want vld 0 clkEn 1 gnt %b",
                        tif.res_vld, nrm_clkEn, tif.req_gnt, exp_gnt);
    end
    step();
    drain(LAT + 1);
  endtask

  task automatic test_kill();
    drive(3'b100, '0, 1'b1); eval(); step();
    drive(3'b100, '0, 1'b1); eval(); step();
    drive('0, 3'b100, 1'b1);
    eval();
    n_cmp++;
    if (tif.res_vld !== 1'b0 || int'(tif.occ) !== 2) begin
      n_bad++; $display("FAIL kill_cycle: got vld %b occ %0d want vld 0 occ 2", tif.res_vld, tif.occ);
    end
    step();
    for (int c = 0; c < 2; c++) begin
      drive('0, '0, 1'b1);
      eval();
      n_cmp++;
      if (tif.res_vld !== 1'b0 || int'(tif.occ) !== exp_occ) begin
        n_bad++; $display("FAIL kill_after: cycle %0d got vld %b occ %0d want vld 0 occ %0d",
                          c, tif.res_vld, tif.occ, exp_occ);
      end
      step();
    end
  endtask

  task automatic test_kill_same_cycle();
    drive(3'b001, 3'b001, 1'b1);
    eval();
    n_cmp++;
    if (tif.req_gnt !== 3'b000 || nrm_en !== 1'b0) begin
      n_bad++; $display("FAIL killreq_gnt: got gnt %b en %b want gnt 000 en 0", tif.req_gnt, nrm_en);
    end
    step();
    drive(3'b111, '0, 1'b1);
    eval();
    n_cmp++;
    if (tif.req_gnt !== exp_gnt) begin
      n_bad++; $display("FAIL killreq_ptr: got %b want %b", tif.req_gnt, exp_gnt);
    end
    step();
    drain(LAT + 1);
  endtask

  task automatic test_reset_mid();
    drive(3'b111, '0, 1'b1); eval(); step();
    drive(3'b111, '0, 1'b1); eval(); step();
    rst = 1'b1;
    drive('0, '0, 1'b1); eval(); step();
    rst = 1'b0;
    for (int c = 0; c < LAT + 1; c++) begin
      drive('0, '0, 1'b1);
      eval();
      n_cmp++;
      if (tif.res_vld !== 1'b0 || tif.occ !== OCCW'(0)) begin
        n_bad++; $display("FAIL rstmid: cycle %0d got vld %b occ %0d want vld 0 occ 0",
                          c, tif.res_vld, tif.occ);
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      logic [NREQ-1:0] kl;
      rst = ($urandom % 150) == 0;
      for (int i = 0; i < NREQ; i++) kl[i] = ($urandom % 12) == 0;
      drive(NREQ'($urandom), kl, ($urandom % 4) != 0);
      eval();
      n_cmp++;
      if (tif.req_gnt !== exp_gnt || nrm_en !== (exp_pick >= 0)) begin
        n_bad++; $display("FAIL rand_gnt: cycle %0d got %b want %b", c, tif.req_gnt, exp_gnt);
      end
      n_cmp++;
      if (nrm_A !== exp_A || nrm_isDBL !== exp_d || nrm_isEXT !== exp_e) begin
        n_bad++; $display("FAIL rand_operand: cycle %0d got %h/%b/%b want %h/%b/%b",
                          c, nrm_A, nrm_isDBL, nrm_isEXT, exp_A, exp_d, exp_e);
      end
      n_cmp++;
      if (nrm_clkEn !== !exp_stall) begin
        n_bad++; $display("FAIL rand_clken: cycle %0d got %b want %b", c, nrm_clkEn, !exp_stall);
      end
      n_cmp++;
      if (tif.res_vld !== exp_res_vld) begin
        n_bad++; $display("FAIL rand_res_vld: cycle %0d got %b want %b", c, tif.res_vld, exp_res_vld);
      end
      if (exp_res_vld) begin
        n_cmp++;
        if (tif.res_src !== exp_src || tif.res_tag !== exp_tag || tif.res_data !== exp_data) begin
          n_bad++; $display("FAIL rand_res: cycle %0d got %b/%h/%h want %b/%h/%h", c,
                            tif.res_src, tif.res_tag, tif.res_data, exp_src, exp_tag, exp_data);
        end
      end
      n_cmp++;
      if (int'(tif.occ) !== exp_occ) begin
        n_bad++; $display("FAIL rand_occ: cycle %0d got %0d want %0d", c, tif.occ, exp_occ);
      end
      step();
    end
    rst = 1'b0;
    drain(LAT + 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rr = 0;
    rst = 1'b1;
    drive('0, '0, 1'b1);
    test_reset();
    test_round_robin();
    test_stall();
    test_kill_stall();
    test_kill();
    test_kill_same_cycle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
